// File: rtl/aes_pkg.sv
// Shared AES helpers: GF(2^8) constant multipliers, FSM encodings and column indices.
// Multipliers are built from xtime chains so each maps to a small XOR network.
package aes_pkg;

  localparam logic [7:0] AES_POLY = 8'h1B;
  localparam int         NCOL     = 4;
  localparam int         NROW     = 4;
  localparam logic [1:0] COL_LAST = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] gmul9(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ a;
  endfunction

  function automatic logic [7:0] gmulb(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
  endfunction

  function automatic logic [7:0] gmuld(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
  endfunction

  function automatic logic [7:0] gmule(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
  endfunction

endpackage

// File: rtl/aes_inv_mixcolumn_word.sv
// Combinational inverse MixColumns of one 32-bit column; byte k of the word is row k.
// Zero latency, no flow control: the output follows the input within the same cycle.
module aes_inv_mixcolumn_word
  import aes_pkg::*;
(
  input  logic [31:0] col_in,
  output logic [31:0] col_out
);

  always_comb begin
    col_out = '0;
    for (int r = 0; r < NROW; r++) begin
      col_out[8*r +: 8] = gmule(col_in[8*r +: 8])
                        ^ gmulb(col_in[8*((r+1)%NROW) +: 8])
                        ^ gmuld(col_in[8*((r+2)%NROW) +: 8])
                        ^ gmul9(col_in[8*((r+3)%NROW) +: 8]);
    end
  end

endmodule

// File: rtl/aes_inv_mixcolumns.sv
// Inverse MixColumns over a 128-bit state, one column per clock through a shared unit.
// Latency: start edge + 4 column edges, done for one cycle; start ignored unless IDLE.
module aes_inv_mixcolumns
  import aes_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start_in,
  input  logic [31:0] state0,
  input  logic [31:0] state1,
  input  logic [31:0] state2,
  input  logic [31:0] state3,
  output logic [31:0] state_out0,
  output logic [31:0] state_out1,
  output logic [31:0] state_out2,
  output logic [31:0] state_out3,
  output logic        done
);

  state_e      state_q, state_d;
  logic [1:0]  col_q, col_d;
  logic [31:0] in_q  [NCOL];
  logic [31:0] in_d  [NCOL];
  logic [31:0] out_q [NCOL];
  logic [31:0] out_d [NCOL];
  logic [31:0] col_sel;
  logic [31:0] col_mix;

  assign col_sel = in_q[col_q];

  aes_inv_mixcolumn_word u_word (
    .col_in  (col_sel),
    .col_out (col_mix)
  );

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    in_d    = in_q;
    out_d   = out_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_in) begin
          in_d[0] = state0;
          in_d[1] = state1;
          in_d[2] = state2;
          in_d[3] = state3;
          col_d   = 2'd0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        out_d[col_q] = col_mix;
        col_d        = col_q + 2'd1;
        if (col_q == COL_LAST) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      col_q   <= 2'd0;
      for (int i = 0; i < NCOL; i++) begin
        in_q[i]  <= 32'h0;
        out_q[i] <= 32'h0;
      end
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      for (int i = 0; i < NCOL; i++) begin
        in_q[i]  <= in_d[i];
        out_q[i] <= out_d[i];
      end
    end
  end

  // Outputs keep the last written columns; only done marks the whole set as valid.
  assign state_out0 = out_q[0];
  assign state_out1 = out_q[1];
  assign state_out2 = out_q[2];
  assign state_out3 = out_q[3];
  assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_aes_inv_mixcolumns.sv
// Bench for aes_inv_mixcolumns: vector table plus hand-written corner sequences,
// expected column sets queued at launch and checked when done is seen.
module tb_aes_inv_mixcolumns;

  logic        clk;
  logic        reset;
  logic        start_in;
  logic [31:0] state0, state1, state2, state3;
  logic [31:0] state_out0, state_out1, state_out2, state_out3;
  logic        done;

  aes_inv_mixcolumns dut (
    .clk        (clk),
    .reset      (reset),
    .start_in   (start_in),
    .state0     (state0),
    .state1     (state1),
    .state2     (state2),
    .state3     (state3),
    .state_out0 (state_out0),
    .state_out1 (state_out1),
    .state_out2 (state_out2),
    .state_out3 (state_out3),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0][31:0] in_w;
    logic [3:0][31:0] exp_w;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [3:0][31:0] sb [$];
  int               done_cyc [$];
  vec_t             vecs [6];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Generic shift-and-add GF(2^8) multiply modulo 0x11B.
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1B) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] w, input logic [7:0] c0,
                                          input logic [7:0] c1, input logic [7:0] c2,
                                          input logic [7:0] c3);
    logic [7:0]  a [4];
    logic [31:0] r;
    for (int k = 0; k < 4; k++) a[k] = w[8*k +: 8];
    r = 32'h0;
    for (int k = 0; k < 4; k++)
      r[8*k +: 8] = gm(c0, a[k]) ^ gm(c1, a[(k+1)%4]) ^ gm(c2, a[(k+2)%4]) ^ gm(c3, a[(k+3)%4]);
    return r;
  endfunction

  function automatic logic [31:0] inv_col(input logic [31:0] w);
    return mix_col(w, 8'h0e, 8'h0b, 8'h0d, 8'h09);
  endfunction

  function automatic logic [31:0] fwd_col(input logic [31:0] w);
    return mix_col(w, 8'h02, 8'h03, 8'h01, 8'h01);
  endfunction

  // Scoreboard monitor: every done must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset && done) begin
      logic [3:0][31:0] e;
      done_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected none at cycle %0d", cyc);
      end else begin
        e = sb.pop_front();
        chk("out0", state_out0, e[0]);
        chk("out1", state_out1, e[1]);
        chk("out2", state_out2, e[2]);
        chk("out3", state_out3, e[3]);
      end
    end
  end

  task automatic drive_state(input logic [3:0][31:0] w);
    state0 = w[0];
    state1 = w[1];
    state2 = w[2];
    state3 = w[3];
  endtask

  task automatic run_op(input logic [3:0][31:0] iw, input logic [3:0][31:0] ew);
    int n;
    @(negedge clk);
    drive_state(iw);
    start_in = 1'b1;
    sb.push_back(ew);
    @(posedge clk);
    @(negedge clk);
    start_in = 1'b0;
    state0 = $urandom; state1 = $urandom; state2 = $urandom; state3 = $urandom;
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(n), 32'd4);
    @(negedge clk);
    chk("done_width", {31'h0, done}, 32'h0);
  endtask

  initial begin
    logic [3:0][31:0] w, e, keep;
    reset = 1'b1;
    start_in = 1'b0;
    state0 = 32'h0; state1 = 32'h0; state2 = 32'h0; state3 = 32'h0;

    vecs[0].in_w  = {32'h0, 32'h0, 32'h0, 32'hbca14d8e};
    vecs[0].exp_w = {32'h0, 32'h0, 32'h0, 32'h455313db};
    vecs[1].in_w  = {32'hf8bd7e4d, 32'hd6d7d5d5, 32'h01010101, 32'h9d58dc9f};
    vecs[1].exp_w = {32'h4c31262d, 32'hd5d4d4d4, 32'h01010101, 32'h5c220af2};
    w = {32'hffeeddcc, 32'hbbaa9988, 32'h77665544, 32'h33221100};
    for (int i = 0; i < 4; i++) vecs[2].in_w[i] = fwd_col(w[i]);
    vecs[2].exp_w = w;
    for (int v = 3; v < 6; v++) begin
      for (int i = 0; i < 4; i++) begin
        vecs[v].in_w[i]  = $urandom;
        vecs[v].exp_w[i] = inv_col(vecs[v].in_w[i]);
      end
    end

    #12;
    chk("rst_out0", state_out0, 32'h0);
    chk("rst_out3", state_out3, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int v = 0; v < 6; v++) run_op(vecs[v].in_w, vecs[v].exp_w);

    // Outputs hold after the operation completes.
    repeat (3) @(negedge clk);
    chk("hold_out0", state_out0, vecs[5].exp_w[0]);
    chk("hold_out2", state_out2, vecs[5].exp_w[2]);

    // start toggled while busy with new inputs: ignored.
    @(negedge clk);
    drive_state(vecs[1].in_w);
    start_in = 1'b1;
    sb.push_back(vecs[1].exp_w);
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      start_in = (n < 5) ? n[0] : 1'b0;
      drive_state(vecs[0].in_w);
    end
    repeat (8) @(negedge clk);
    chk("ign_sb_empty", 32'(sb.size()), 32'd0);
    chk("ign_out3", state_out3, vecs[1].exp_w[3]);

    // start held high for 20 edges: relaunch every 6 cycles.
    @(negedge clk);
    done_cyc.delete();
    drive_state(vecs[2].in_w);
    start_in = 1'b1;
    for (int k = 0; k < 4; k++) sb.push_back(vecs[2].exp_w);
    repeat (20) @(posedge clk);
    @(negedge clk);
    start_in = 1'b0;
    repeat (12) @(negedge clk);
    chk("hold_pulses", 32'(done_cyc.size()), 32'd4);
    for (int k = 1; k < done_cyc.size(); k++)
      chk("hold_interval", 32'(done_cyc[k] - done_cyc[k-1]), 32'd6);

    // Reset in the middle of BUSY: immediate clear, no later done.
    @(negedge clk);
    drive_state(vecs[3].in_w);
    start_in = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_out0", state_out0, 32'h0);
    chk("arst_out1", state_out1, 32'h0);
    chk("arst_out2", state_out2, 32'h0);
    chk("arst_out3", state_out3, 32'h0);
    chk("arst_done", {31'h0, done}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    chk("arst_sb_empty", 32'(sb.size()), 32'd0);

    // Normal operation after the aborted one.
    for (int i = 0; i < 4; i++) e[i] = inv_col(vecs[4].in_w[i]);
    keep = vecs[4].in_w;
    run_op(keep, e);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
